// File: rtl/systolic_array_c_writer_pkg.sv
// Shared types and sizing helpers for the C write-back path of the systolic matrix multiplier.
package systolic_array_c_writer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } cw_state_e;

    localparam int unsigned CW_ADDRESS_WIDTH = 16;
    localparam int unsigned CW_DIM_WIDTH     = 16;

    // Elements that fit in one bus word.
    function automatic int unsigned cw_epw(input int unsigned cb, input int unsigned bus_bytes);
        return bus_bytes / cb;
    endfunction

    // Bus words needed to carry valid_elems elements.
    function automatic int unsigned cw_words_per_vec(input int unsigned valid_elems, input int unsigned epw);
        return (valid_elems + epw - 32'd1) / epw;
    endfunction

endpackage

// File: rtl/systolic_array_c_writer_if.sv
// Result-vector input and write-request output channels of the C writer.
interface systolic_array_c_writer_if #(
    parameter int unsigned ARRAY_HEIGHT    = 32,
    parameter int unsigned C_WIDTH_BYTES   = 4,
    parameter int unsigned BUS_WIDTH_BYTES = 32,
    parameter int unsigned ADDRESS_WIDTH   = 16
);
    logic                                   res_valid_i;
    logic                                   res_ready_o;
    logic [ARRAY_HEIGHT*C_WIDTH_BYTES*8-1:0] res_data_i;
    logic                                   wr_valid_o;
    logic                                   wr_ready_i;
    logic [ADDRESS_WIDTH-1:0]               wr_addr_o;
    logic [BUS_WIDTH_BYTES*8-1:0]           wr_data_o;
    logic [BUS_WIDTH_BYTES-1:0]             wr_strb_o;

    modport master (
        input  res_valid_i, res_data_i, wr_ready_i,
        output res_ready_o, wr_valid_o, wr_addr_o, wr_data_o, wr_strb_o
    );

    modport slave (
        output res_valid_i, res_data_i, wr_ready_i,
        input  res_ready_o, wr_valid_o, wr_addr_o, wr_data_o, wr_strb_o
    );
endinterface

// File: rtl/systolic_array_c_writer_serializer.sv
// Holds one result vector and presents it as a sequence of bus words with element-granular strobes.
module systolic_array_c_writer_serializer
    import systolic_array_c_writer_pkg::*;
#(
    parameter int unsigned ARRAY_HEIGHT    = 32,
    parameter int unsigned C_WIDTH_BYTES   = 4,
    parameter int unsigned BUS_WIDTH_BYTES = 32,
    localparam int unsigned EW             = $clog2(ARRAY_HEIGHT + 1)
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    load_i,
    input  logic                                    advance_i,
    input  logic [ARRAY_HEIGHT*C_WIDTH_BYTES*8-1:0] vec_i,
    input  logic [EW-1:0]                           valid_elems_i,
    output logic [BUS_WIDTH_BYTES*8-1:0]            word_o,
    output logic [BUS_WIDTH_BYTES-1:0]              strb_o,
    output logic                                    last_o
);
    localparam int unsigned EPW = cw_epw(C_WIDTH_BYTES, BUS_WIDTH_BYTES);
    localparam int unsigned WPV = ARRAY_HEIGHT / EPW;
    localparam int unsigned WCW = (WPV > 1) ? $clog2(WPV) : 1;
    localparam int unsigned WW  = BUS_WIDTH_BYTES * 8;

    logic [WPV-1:0][WW-1:0]        vec_q, vec_d;
    logic [WCW-1:0]                word_cnt_q, word_cnt_d;
    logic [WCW-1:0]                nlast_q, nlast_d;
    logic [EW-1:0]                 nvalid_q, nvalid_d;
    logic [WW-1:0]                 word_q, word_d;
    logic [BUS_WIDTH_BYTES-1:0]    strb_q, strb_d;

    function automatic logic [BUS_WIDTH_BYTES-1:0] word_strobe(input logic [EW-1:0] nvalid,
                                                              input logic [WCW-1:0] widx);
        logic [BUS_WIDTH_BYTES-1:0] s;
        s = '0;
        for (int unsigned k = 0; k < EPW; k++) begin
            if ((32'(widx) * EPW + k) < 32'(nvalid)) begin
                s[k*C_WIDTH_BYTES +: C_WIDTH_BYTES] = '1;
            end else begin
                s[k*C_WIDTH_BYTES +: C_WIDTH_BYTES] = '0;
            end
        end
        return s;
    endfunction

    // Capture a new vector or step to the next word slice.
    always_comb begin
        vec_d      = vec_q;
        word_cnt_d = word_cnt_q;
        nlast_d    = nlast_q;
        nvalid_d   = nvalid_q;
        word_d     = word_q;
        strb_d     = strb_q;
        if (load_i) begin
            vec_d      = vec_i;
            word_cnt_d = '0;
            nvalid_d   = valid_elems_i;
            nlast_d    = WCW'(cw_words_per_vec(32'(valid_elems_i), EPW) - 32'd1);
            word_d     = vec_i[WW-1:0];
            strb_d     = word_strobe(valid_elems_i, '0);
        end else if (advance_i) begin
            word_cnt_d = word_cnt_q + WCW'(1);
            word_d     = vec_q[word_cnt_d];
            strb_d     = word_strobe(nvalid_q, word_cnt_d);
        end else begin
            word_d     = word_q;
        end
    end

    // Holding register and presented word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vec_q      <= '0;
            word_cnt_q <= '0;
            nlast_q    <= '0;
            nvalid_q   <= '0;
            word_q     <= '0;
            strb_q     <= '0;
        end else begin
            vec_q      <= vec_d;
            word_cnt_q <= word_cnt_d;
            nlast_q    <= nlast_d;
            nvalid_q   <= nvalid_d;
            word_q     <= word_d;
            strb_q     <= strb_d;
        end
    end

    assign word_o = word_q;
    assign strb_o = strb_q;
    assign last_o = (word_cnt_q == nlast_q);

endmodule

// File: rtl/systolic_array_c_writer.sv
// C write-back: accepts result vectors from the array and issues one strobed write per bus word.
module systolic_array_c_writer
    import systolic_array_c_writer_pkg::*;
#(
    parameter int unsigned ARRAY_HEIGHT    = 32,
    parameter int unsigned C_WIDTH_BYTES   = 4,
    parameter int unsigned BUS_WIDTH_BYTES = 32,
    parameter int unsigned ADDRESS_WIDTH   = CW_ADDRESS_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start_i,
    input  logic [CW_DIM_WIDTH-1:0]   m,
    input  logic [CW_DIM_WIDTH-1:0]   p,
    input  logic [ADDRESS_WIDTH-1:0]  base_addr_c,
    systolic_array_c_writer_if.master bus,
    output logic                      busy_o,
    output logic                      done_o
);
    localparam int unsigned SEG_BYTES = ARRAY_HEIGHT * C_WIDTH_BYTES;
    localparam int unsigned EW        = $clog2(ARRAY_HEIGHT + 1);
    localparam int unsigned DW        = CW_DIM_WIDTH;

    cw_state_e                state_q, state_d;
    logic [DW-1:0]            m_q, m_d, p_q, p_d, segs_q, segs_d;
    logic [DW-1:0]            row_q, row_d, seg_q, seg_d;
    logic [ADDRESS_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
    logic                     res_ready_q, res_ready_d, wr_valid_q, wr_valid_d;
    logic                     busy_q, busy_d, done_q, done_d;

    logic                     res_hs_s, wr_hs_s, word_last_s, last_vec_s;
    logic [31:0]              seg_rem_s, pitch_s;
    logic [EW-1:0]            valid_elems_s;
    logic [BUS_WIDTH_BYTES*8-1:0] word_s;
    logic [BUS_WIDTH_BYTES-1:0]   strb_s;

    assign res_hs_s   = res_ready_q && bus.res_valid_i;
    assign wr_hs_s    = wr_valid_q && bus.wr_ready_i;
    assign last_vec_s = (row_q == m_q - DW'(1)) && (seg_q == segs_q - DW'(1));
    // Every row occupies a whole number of segments so each segment starts bus-aligned.
    assign pitch_s    = 32'(segs_q) * SEG_BYTES;
    assign seg_rem_s  = 32'(p_q) - 32'(seg_q) * ARRAY_HEIGHT;
    assign valid_elems_s = (seg_rem_s > ARRAY_HEIGHT) ? EW'(ARRAY_HEIGHT) : EW'(seg_rem_s);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = ((m == '0) || (p == '0)) ? DONE : LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (res_hs_s) begin
                    state_d = SEND;
                end else begin
                    state_d = LOAD;
                end
            end
            SEND: begin
                if (wr_hs_s && word_last_s) begin
                    state_d = last_vec_s ? DONE : LOAD;
                end else begin
                    state_d = SEND;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode, registered so the ports come straight from flops.
    always_comb begin
        res_ready_d = (state_d == LOAD);
        wr_valid_d  = (state_d == SEND);
        busy_d      = (state_d != IDLE);
        done_d      = (state_q == DONE);
    end

    // Job parameters, row/segment counters and word address.
    always_comb begin
        m_d    = m_q;
        p_d    = p_q;
        base_d = base_q;
        segs_d = segs_q;
        row_d  = row_q;
        seg_d  = seg_q;
        addr_d = addr_q;
        if ((state_q == IDLE) && start_i) begin
            m_d    = m;
            p_d    = p;
            base_d = base_addr_c;
            segs_d = DW'((32'(p) + ARRAY_HEIGHT - 32'd1) / ARRAY_HEIGHT);
            row_d  = '0;
            seg_d  = '0;
        end else if (res_hs_s) begin
            addr_d = ADDRESS_WIDTH'(32'(base_q) + 32'(row_q) * pitch_s + 32'(seg_q) * SEG_BYTES);
        end else if (wr_hs_s) begin
            if (!word_last_s) begin
                addr_d = addr_q + ADDRESS_WIDTH'(BUS_WIDTH_BYTES);
            end else if (seg_q == segs_q - DW'(1)) begin
                seg_d = '0;
                row_d = row_q + DW'(1);
            end else begin
                seg_d = seg_q + DW'(1);
            end
        end else begin
            addr_d = addr_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q         <= '0;
            p_q         <= '0;
            base_q      <= '0;
            segs_q      <= '0;
            row_q       <= '0;
            seg_q       <= '0;
            addr_q      <= '0;
            res_ready_q <= 1'b0;
            wr_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            m_q         <= m_d;
            p_q         <= p_d;
            base_q      <= base_d;
            segs_q      <= segs_d;
            row_q       <= row_d;
            seg_q       <= seg_d;
            addr_q      <= addr_d;
            res_ready_q <= res_ready_d;
            wr_valid_q  <= wr_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    systolic_array_c_writer_serializer #(
        .ARRAY_HEIGHT    (ARRAY_HEIGHT),
        .C_WIDTH_BYTES   (C_WIDTH_BYTES),
        .BUS_WIDTH_BYTES (BUS_WIDTH_BYTES)
    ) u_serializer (
        .clk           (clk),
        .reset_n       (reset_n),
        .load_i        (res_hs_s),
        .advance_i     (wr_hs_s && !word_last_s),
        .vec_i         (bus.res_data_i),
        .valid_elems_i (valid_elems_s),
        .word_o        (word_s),
        .strb_o        (strb_s),
        .last_o        (word_last_s)
    );

    assign bus.res_ready_o = res_ready_q;
    assign bus.wr_valid_o  = wr_valid_q;
    assign bus.wr_addr_o   = addr_q;
    assign bus.wr_data_o   = word_s;
    assign bus.wr_strb_o   = strb_s;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

endmodule
